prime_check: RTL and testbench
==============================

// Module: prime_check
// PURPOSE
//  - Sequential primality tester; the consumer-side counterpart of primogen: accepts a candidate, returns prime/composite.
//  - Method: trial division by odd d = 3,5,7,... while d*d <= n; one restoring-division remainder per trial.
//  - Sits downstream of primogen in benches to cross-check every generated prime on-chip.
//  - Handshake style matches primogen: go / ready / error.
// PARAMETERS
//  - WIDTH_LOG  4  log2 of operand width; W = 1 << WIDTH_LOG; legal values 3..5.
// PORTS
//  - clk       in   1      clock.
//  - rst       in   1      reset: synchronous, active-high.
//  - go        in   1      start request; sampled only on cycles where ready=1.
//  - n         in   W      candidate; registered on the accepting cycle.
//  - ready     out  1      1 = idle and results valid; 0 = busy.
//  - error     out  1      go seen while busy (sticky).
//  - is_prime  out  1      result: 1 iff n is prime.
//  - factor    out  W      smallest divisor > 1 if composite; 0 if prime or n < 2.
//  - cycles    out  16     (only with PRIME_CHECK_STATS_EN) busy cycles of the last check.
// BEHAVIOUR
//  - Reset values (cycle after rst=1):
//      ready=1, error=0, is_prime=0, factor=0, cycles=0; FSM in IDLE.
//  - rst mid-operation aborts the check; no partial result is ever presented.
//  - Accept: go=1 && ready=1 at edge t -> n latched, ready=0 from t+1.
//      - Accept also clears error, is_prime and factor.
//  - go=1 && ready=0 -> error=1 at next edge; held until next accepted go or rst; running check unaffected.
//  - Results change only at the ready 0->1 edge and are held stable while ready=1.
//  - FSM states: IDLE, TRIV, CMP, DIV, STEP.
//  - IDLE: ready=1; on accept -> TRIV.
//  - TRIV (1 cycle):
//      - n<2 -> is_prime=0, factor=0.
//      - n==2 || n==3 -> is_prime=1.
//      - n even -> factor=2.
//      - In all three cases -> IDLE; ready=1 two edges after the accepting edge.
//      - Otherwise d=3, sq=9 -> CMP.
//  - CMP (1 cycle):
//      - sq > n -> is_prime=1, factor=0 -> IDLE.
//      - Else clear remainder, load quotient shift reg with n, bit counter=W -> DIV.
//  - DIV (W cycles): restoring step per cycle.
//      - rem = {rem, msb(q)}; if rem >= d subtract d; decrement counter.
//      - Counter reaches 0 -> STEP.
//  - STEP (1 cycle):
//      - rem==0 -> is_prime=0, factor=d -> IDLE.
//      - Else sq <= sq + 4*d + 4 (old d), d <= d + 2 -> CMP.
//  - Widths: d is W/2+2 bits; sq is W+2 bits (no overflow for any W-bit n); rem is W/2+3 bits; all compares unsigned.
//  - Boundary: sq == n counts as a trial (n=9, 25, 49 composite).
//  - Per odd trial: W+2 cycles. Worst case (largest W-bit prime): ~(2^(W/2)/2)*(W+2) cycles.
// CONFIGURATION
//  - PRIME_CHECK_STATS_EN defined:
//      - 16-bit counter counts cycles with ready=0, saturating at 16'hFFFF.
//      - Copied to cycles at the ready 0->1 edge; cycles reset to 0.
//  - Undefined: cycles port and counter absent; all other behaviour identical.
// TESTING
//  - (W=16 throughout.)
//  - rst, then n=0, n=1, n=2, n=4 each with go:
//      - is_prime/factor = 0/0, 0/0, 1/0, 0/2.
//      - Each with ready low exactly 2 cycles.
//  - n=9 -> is_prime=0, factor=3.
//  - n=25 -> is_prime=0, factor=5 (sq==n boundary).
//  - n=91 -> factor=7.
//  - n=65521 -> is_prime=1, factor=0.
//  - Stream all primogen outputs up to 65521 into go/n -> is_prime=1 for every one; compare against software sieve.
//  - n=65521 started, then go pulsed at busy cycle 10:
//      - error=1 next cycle and stays 1; final result still is_prime=1.
//      - Next accepted go clears error.
//  - rst asserted 50 cycles into n=65521 -> next cycle ready=1, is_prime=0, factor=0, error=0.
//  - STATS_EN: n=4 -> cycles=2; n=9 -> cycles = 1 + 1 + (W+2) = 20.

Source files
------------

// File: rtl/prime_check.sv
// Sequential trial-division primality tester with go/ready/error handshake.
// Define PRIME_CHECK_STATS_EN to add the busy-cycle counter and cycles port.
module prime_check #(
    parameter int WIDTH_LOG = 4,
    localparam int W = 1 << WIDTH_LOG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] n,
    output logic         ready,
    output logic         error,
    output logic         is_prime,
    output logic [W-1:0] factor
`ifdef PRIME_CHECK_STATS_EN
    ,
    output logic [15:0]  cycles
`endif
);

    localparam int DW = W / 2 + 2;
    localparam int SW = W + 2;
    localparam int RW = W / 2 + 3;
    localparam int CW = WIDTH_LOG + 1;

    typedef enum logic [2:0] {
        IDLE,
        TRIV,
        CMP,
        DIV,
        STEP
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  n_q;
    logic [DW-1:0] d;
    logic [SW-1:0] sq;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_sh;
    logic [RW-1:0] rem_next;
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          res_prime;
    logic [W-1:0]  res_factor;
    logic          accept;
    logic          trivial;
    logic          sq_gt_n;

    always_comb begin
        accept     = go && ready;
        trivial    = (n_q < W'(4)) || !n_q[0];
        sq_gt_n    = sq > {2'b00, n_q};
        rem_sh     = {rem[RW-2:0], q[W-1]};
        rem_next   = rem_sh;
        if (rem_sh >= RW'(d))
            rem_next = rem_sh - RW'(d);
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = TRIV;
            TRIV: state_next = trivial ? IDLE : CMP;
            CMP:  state_next = sq_gt_n ? IDLE : DIV;
            DIV:  if (cnt == CW'(1)) state_next = STEP;
            STEP: state_next = (rem == '0) ? IDLE : CMP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Results are staged in res_* and only published on the ready rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready      <= 1'b1;
            error      <= 1'b0;
            is_prime   <= 1'b0;
            factor     <= '0;
            res_prime  <= 1'b0;
            res_factor <= '0;
            n_q        <= '0;
            d          <= '0;
            sq         <= '0;
            rem        <= '0;
            q          <= '0;
            cnt        <= '0;
        end else begin
            if (go && !ready)
                error <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        n_q      <= n;
                        ready    <= 1'b0;
                        error    <= 1'b0;
                        is_prime <= 1'b0;
                        factor   <= '0;
                    end else if (!ready) begin
                        ready    <= 1'b1;
                        is_prime <= res_prime;
                        factor   <= res_factor;
                    end
                end
                TRIV: begin
                    res_prime  <= 1'b0;
                    res_factor <= '0;
                    if (n_q == W'(2) || n_q == W'(3))
                        res_prime <= 1'b1;
                    else if (n_q >= W'(2) && !n_q[0])
                        res_factor <= W'(2);
                    d  <= DW'(3);
                    sq <= SW'(9);
                end
                CMP: begin
                    if (sq_gt_n) begin
                        res_prime  <= 1'b1;
                        res_factor <= '0;
                    end else begin
                        rem <= '0;
                        q   <= n_q;
                        cnt <= CW'(W);
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    q   <= {q[W-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                end
                STEP: begin
                    if (rem == '0) begin
                        res_prime  <= 1'b0;
                        res_factor <= W'(d);
                    end else begin
                        sq <= sq + {d, 2'b00} + SW'(4);
                        d  <= d + DW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PRIME_CHECK_STATS_EN
    logic [15:0] busy_cnt;
    logic [15:0] busy_inc;

    always_comb begin
        busy_inc = (busy_cnt == 16'hFFFF) ? busy_cnt : busy_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
            cycles   <= '0;
        end else if (accept) begin
            busy_cnt <= '0;
        end else if (!ready) begin
            busy_cnt <= busy_inc;
            if (state == IDLE)
                cycles <= busy_inc;
        end
    end
`endif

endmodule

// File: tb/tb_prime_check.sv
// Directed-vector bench for prime_check at W=16, with a small sieve
// model for the streamed range and hand sequences for error and reset.
module tb_prime_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [15:0] n;
    logic        ready;
    logic        error;
    logic        is_prime;
    logic [15:0] factor;
`ifdef PRIME_CHECK_STATS_EN
    logic [15:0] cycles;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    prime_check #(.WIDTH_LOG(4)) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .n(n),
        .ready(ready),
        .error(error),
        .is_prime(is_prime),
        .factor(factor)
`ifdef PRIME_CHECK_STATS_EN
        ,
        .cycles(cycles)
`endif
    );

    typedef struct {
        int n;
        int prime;
        int fac;
        int low;
    } vec_t;

    vec_t tab[$];
    int   spf[256];

    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ready(output int low);
        low = 0;
        while (!ready && low < 5000) begin
            low++;
            @(negedge clk);
        end
        if (!ready)
            check("ready_timeout", 0, 1);
    endtask

    task automatic start(input int v);
        @(negedge clk);
        go = 1'b1;
        n  = 16'(v);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run(input int v, output int low);
        start(v);
        wait_ready(low);
    endtask

    initial begin
        int low;
        string nm;
        rst = 1'b1;
        go  = 1'b0;
        n   = '0;

        tab.push_back('{0, 0, 0, 2});
        tab.push_back('{1, 0, 0, 2});
        tab.push_back('{2, 1, 0, 2});
        tab.push_back('{4, 0, 2, 2});
        tab.push_back('{3, 1, 0, 2});
        tab.push_back('{6, 0, 2, 2});
        tab.push_back('{9, 0, 3, 20});
        tab.push_back('{25, 0, 5, 38});
        tab.push_back('{91, 0, 7, -1});
        tab.push_back('{15, 0, 3, -1});
        tab.push_back('{49, 0, 7, -1});
        tab.push_back('{97, 1, 0, -1});
        tab.push_back('{221, 0, 13, -1});
        tab.push_back('{65535, 0, 3, -1});
        tab.push_back('{64009, 0, 11, -1});
        tab.push_back('{65521, 1, 0, -1});

        for (int i = 0; i < 256; i++)
            spf[i] = 0;
        for (int p = 2; p < 256; p++) begin
            if (spf[p] == 0) begin
                spf[p] = p;
                for (int m = p * p; m < 256; m += p)
                    if (spf[m] == 0)
                        spf[m] = p;
            end
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_error", int'(error), 0);
        check("rst_prime", int'(is_prime), 0);
        check("rst_factor", int'(factor), 0);
`ifdef PRIME_CHECK_STATS_EN
        check("rst_cycles", int'(cycles), 0);
`endif
        rst = 1'b0;

        foreach (tab[i]) begin
            run(tab[i].n, low);
            nm = $sformatf("n%0d", tab[i].n);
            check({nm, "_prime"}, int'(is_prime), tab[i].prime);
            check({nm, "_factor"}, int'(factor), tab[i].fac);
            if (tab[i].low >= 0)
                check({nm, "_low"}, low, tab[i].low);
        end

        for (int v = 0; v < 256; v++) begin
            int ep;
            int ef;
            ep = (v >= 2 && spf[v] == v) ? 1 : 0;
            ef = (v >= 2 && spf[v] != v) ? spf[v] : 0;
            run(v, low);
            nm = $sformatf("sieve%0d", v);
            check({nm, "_prime"}, int'(is_prime), ep);
            check({nm, "_factor"}, int'(factor), ef);
        end

        // go while busy: error sticks, the running check finishes normally
        start(65521);
        repeat (9) @(negedge clk);
        go = 1'b1;
        n  = 16'd4;
        @(negedge clk);
        go = 1'b0;
        check("err_set", int'(error), 1);
        check("err_busy", int'(ready), 0);
        wait_ready(low);
        check("err_held", int'(error), 1);
        check("err_prime", int'(is_prime), 1);
        check("err_factor", int'(factor), 0);
        start(9);
        check("err_clear", int'(error), 0);
        wait_ready(low);
        check("err_n9_factor", int'(factor), 3);

        // reset mid-check discards everything
        start(65521);
        repeat (19) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_error", int'(error), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_ready", int'(ready), 1);
        check("mid_prime", int'(is_prime), 0);
        check("mid_factor", int'(factor), 0);
        check("mid_error_clr", int'(error), 0);
        @(negedge clk);
        check("mid_hold", int'(ready), 1);
        run(2, low);
        check("post_rst_prime", int'(is_prime), 1);

`ifdef PRIME_CHECK_STATS_EN
        run(4, low);
        check("stats_n4", int'(cycles), 2);
        run(9, low);
        check("stats_n9", int'(cycles), 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
